// File: rtl/distribute.sv
// distribute: steers a serial data bit onto one of four registered outputs,
// either by explicit address or sequentially as 4-bit frames, with frame
// capture into P and a one-cycle completion pulse.
module distribute (
    input  logic       clk,
    input  logic       reset,
    input  logic       D,
    input  logic [1:0] addr,
    input  logic       N,
    input  logic       mode,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic [3:0] P,
    output logic [1:0] ptr,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_q;
    logic [3:0] w_q_next;
    logic [3:0] r_p;
    logic [3:0] w_p_next;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_next;
    logic       r_done;
    logic       w_done_next;

    // State register: all outputs are registered and cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q     <= 4'b0000;
            r_p     <= 4'b0000;
            r_ptr   <= 2'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_p     <= w_p_next;
            r_ptr   <= w_ptr_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic: N high freezes everything; otherwise the mode
    // sampled at this edge selects addressed or sequential writing.
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_p_next     = r_p;
        w_ptr_next   = r_ptr;
        w_done_next  = 1'b0;
        if (!N) begin
            if (!mode) begin
                // Addressed write; also aborts any partial frame.
                w_q_next[addr] = D;
                w_ptr_next     = 2'd0;
                w_state_next   = S_IDLE;
            end else begin
                w_q_next[r_ptr] = D;
                w_ptr_next      = r_ptr + 2'd1;
                if (r_ptr == 2'd3) begin
                    // Last bit of the frame: capture it together with Q2..Q0.
                    w_p_next     = {D, r_q[2:0]};
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_FILL;
                end
            end
        end
    end

    assign Q0   = r_q[0];
    assign Q1   = r_q[1];
    assign Q2   = r_q[2];
    assign Q3   = r_q[3];
    assign P    = r_p;
    assign ptr  = r_ptr;
    assign busy = (r_state == S_FILL);
    assign done = r_done;

endmodule
